// File: rtl/video_scaler_packer.sv
// RGB565 crop / decimate / pad front end that packs pixels into DDR-width words
// and buffers them in a FIFO drained by the DDR write arbiter.
module video_scaler_packer #(
  parameter int         DQ_WIDTH     = 32,
  parameter int         VIDEO_WIDTH  = 1280,
  parameter int         VIDEO_HEIGHT = 720,
  parameter int         OUT_LINE_PIX = 960,
  parameter int         FIFO_AW      = 6,
  parameter int         BURST_LEN    = 16,
  parameter logic [3:0] IMAGE_TAG    = 4'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vs_in,
  input  logic                    de_in,
  input  logic [15:0]             rgb565_in,
  input  logic [3:0]              h_keep,
  input  logic [3:0]              h_period,
  input  logic [3:0]              v_keep,
  input  logic [3:0]              v_period,
  input  logic [10:0]             row_start,
  input  logic                    rd_en,
  output logic [DQ_WIDTH*8-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    burst_ready,
  output logic [3:0]              trans_id,
  output logic                    overflow,
  output logic                    frame_done,
  output logic [1:0]              dbg_state
);

  localparam int W        = DQ_WIDTH * 8;
  localparam int PPW      = W / 16;
  localparam int PCW      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int OUT_CLIP = (OUT_LINE_PIX < VIDEO_WIDTH) ? OUT_LINE_PIX : VIDEO_WIDTH;

  localparam logic [10:0]      OUT_PIX   = 11'(OUT_CLIP);
  localparam logic [10:0]      LAST_ROW  = 11'(VIDEO_HEIGHT - 1);
  localparam logic [10:0]      END_ROW   = 11'(VIDEO_HEIGHT);
  localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_BURST = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [PCW-1:0]   LAST_SLOT = PCW'(PPW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LINE = 2'd1, ACTIVE = 2'd2, PAD = 2'd3} state_t;

  state_t            state, state_n;
  logic              vs_d, de_d;
  logic [3:0]        hk, hp, vk, vp;
  logic [10:0]       rs, in_row, out_pix;
  logic [3:0]        v_ph, h_ph;
  logic [W-1:0]      pack_buf, pack_next, word_q, push_q;
  logic [PCW-1:0]    pack_cnt;
  logic              word_v, push_v;
  logic [W-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;

  // Any zero or keep-greater-than-period ratio degrades to pass-through.
  function automatic logic [7:0] sanitize(input logic [3:0] k, input logic [3:0] p);
    if (p == 4'd0 || k == 4'd0 || k > p) return {4'd1, 4'd1};
    return {k, p};
  endfunction

  function automatic logic [3:0] ph_next(input logic [3:0] ph, input logic [3:0] per);
    return (ph + 4'd1 >= per) ? 4'd0 : ph + 4'd1;
  endfunction

  logic frame_start, de_rise, de_fall, row_elig, row_kept;
  logic line_start, pad_abort, in_line, pix_keep, pad_pix, pix_v;
  logic [3:0]     h_ph_eff;
  logic [10:0]    out_eff;
  logic [PCW-1:0] slot;
  logic           pop, push_ok, frame_done_n;

  assign frame_start = vs_in & ~vs_d;
  assign de_rise     = de_in & ~de_d;
  assign de_fall     = ~de_in & de_d;
  assign row_elig    = (in_row >= rs) && (in_row < END_ROW);
  assign row_kept    = row_elig && (v_ph < vk);
  assign line_start  = de_rise && row_kept && (state != IDLE);
  assign pad_abort   = (state == PAD) && de_rise;
  assign in_line     = line_start || ((state == ACTIVE) && de_in);
  assign h_ph_eff    = de_rise ? 4'd0 : h_ph;
  assign out_eff     = line_start ? 11'd0 : out_pix;
  assign pix_keep    = in_line && (h_ph_eff < hk) && (out_eff < OUT_PIX);
  assign pad_pix     = (state == PAD) && !de_rise && (out_pix < OUT_PIX);
  assign pix_v       = !frame_start && (pix_keep || pad_pix);
  // A line cut short by a new de_in restarts the packer at slot 0.
  assign slot        = pad_abort ? '0 : pack_cnt;
  assign dbg_state   = state;

  always_comb begin
    pack_next = pack_buf;
    pack_next[16*int'(slot) +: 16] = pad_pix ? 16'd0 : rgb565_in;
  end

  always_comb begin
    state_n = state;
    if (frame_start) begin
      state_n = WAIT_LINE;
    end else begin
      case (state)
        IDLE:      state_n = IDLE;
        WAIT_LINE: if (line_start) state_n = ACTIVE;
        ACTIVE:    if (de_fall) state_n = (out_pix < OUT_PIX) ? PAD : WAIT_LINE;
        PAD: begin
          if (de_rise) state_n = line_start ? ACTIVE : WAIT_LINE;
          else if (out_pix >= OUT_PIX - 11'd1) state_n = WAIT_LINE;
        end
        default:   state_n = IDLE;
      endcase
    end
  end

  // In PAD the row counter has already advanced past the line being padded.
  assign frame_done_n = !frame_start && (state != IDLE) &&
    ((de_fall && (in_row == LAST_ROW) && !row_kept) ||
     ((state == ACTIVE) && de_fall && (in_row == LAST_ROW) && (out_pix >= OUT_PIX)) ||
     ((state == PAD) && !de_rise && (out_pix == OUT_PIX - 11'd1) && (in_row == END_ROW)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_d <= 1'b0;  de_d <= 1'b0;
      hk <= 4'd1; hp <= 4'd1; vk <= 4'd1; vp <= 4'd1; rs <= 11'd0;
      in_row <= 11'd0; v_ph <= 4'd0; h_ph <= 4'd0; out_pix <= 11'd0;
      pack_buf <= '0; pack_cnt <= '0; word_q <= '0; word_v <= 1'b0;
      push_q <= '0; push_v <= 1'b0;
      overflow <= 1'b0; frame_done <= 1'b0;
    end else begin
      vs_d       <= vs_in;
      de_d       <= de_in;
      frame_done <= frame_done_n;
      if (frame_start) begin
        {hk, hp} <= sanitize(h_keep, h_period);
        {vk, vp} <= sanitize(v_keep, v_period);
        rs       <= row_start;
        in_row   <= 11'd0;
        v_ph     <= 4'd0;
        h_ph     <= 4'd0;
        out_pix  <= 11'd0;
        pack_cnt <= '0;
        word_v   <= 1'b0;
        push_v   <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (de_fall) begin
          in_row <= in_row + 11'd1;
          if (row_elig) v_ph <= ph_next(v_ph, vp);
        end
        if (de_in) h_ph <= ph_next(h_ph_eff, hp);
        if (line_start) out_pix <= {10'd0, pix_keep};
        else if (pix_v) out_pix <= out_pix + 11'd1;
        if (pix_v) begin
          pack_buf <= pack_next;
          pack_cnt <= (slot == LAST_SLOT) ? '0 : slot + PCW'(1);
        end else if (pad_abort) begin
          pack_cnt <= '0;
        end
        word_v <= pix_v && (slot == LAST_SLOT);
        if (pix_v && (slot == LAST_SLOT)) word_q <= pack_next;
        push_v <= word_v;
        push_q <= word_q;
        if (pad_abort || (push_v && !push_ok)) overflow <= 1'b1;
      end
    end
  end

  // rd_en is a pop request; it is honoured only while fifo_level is nonzero,
  // and the popped word appears on rd_data with rd_valid high the next cycle.
  assign pop     = rd_en && (fifo_level != '0) && !frame_start;
  assign push_ok = push_v && !frame_start && ((fifo_level < LVL_FULL) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= push_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; fifo_level <= '0;
      rd_data <= '0; rd_valid <= 1'b0;
      burst_ready <= 1'b0; trans_id <= 4'd0;
    end else begin
      burst_ready <= (fifo_level >= LVL_BURST);
      trans_id    <= (fifo_level >= LVL_BURST) ? IMAGE_TAG : 4'd0;
      if (frame_start) begin
        wp <= '0; rp <= '0; fifo_level <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (push_ok) wp <= wp + FIFO_AW'(1);
        if (pop) begin
          rd_data <= mem[rp];
          rp      <= rp + FIFO_AW'(1);
        end
        rd_valid <= pop;
        case ({push_ok, pop})
          2'b10:   fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
          2'b01:   fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
          default: fifo_level <= fifo_level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_scaler_packer.sv
// Scoreboard bench for video_scaler_packer on a reduced frame geometry:
// a line/row-level model fills exp_q, a negedge monitor checks every popped word.
module tb_video_scaler_packer;

  localparam int DQ    = 8;
  localparam int W     = DQ * 8;
  localparam int PPW   = W / 16;
  localparam int VW    = 20;
  localparam int VH    = 10;
  localparam int OLP   = 12;
  localparam int FAW   = 4;
  localparam int DEPTH = 1 << FAW;
  localparam int BL    = 4;
  localparam int GAP   = 16;
  localparam int WPL   = OLP / PPW;

  logic           clk, rst, vs_in, de_in, rd_en;
  logic [15:0]    rgb565_in;
  logic [3:0]     h_keep, h_period, v_keep, v_period;
  logic [10:0]    row_start;
  logic [W-1:0]   rd_data;
  logic           rd_valid, burst_ready, overflow, frame_done;
  logic [FAW:0]   fifo_level;
  logic [3:0]     trans_id;
  logic [1:0]     dbg_state;

  video_scaler_packer #(
    .DQ_WIDTH(DQ), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH), .OUT_LINE_PIX(OLP),
    .FIFO_AW(FAW), .BURST_LEN(BL), .IMAGE_TAG(4'd1)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rgb565_in(rgb565_in),
    .h_keep(h_keep), .h_period(h_period), .v_keep(v_keep), .v_period(v_period),
    .row_start(row_start), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_level(fifo_level), .burst_ready(burst_ready), .trans_id(trans_id),
    .overflow(overflow), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int           pop_q[$];
  int           n_cmp, n_fail, fd_cnt, rx_cnt, cyc, model_words;
  bit           rd_mode;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock step; the read side is driven here so rd_en has a single driver.
  task automatic tick();
    logic forced;
    @(posedge clk);
    #1;
    cyc++;
    forced = 1'b0;
    if (pop_q.size() > 0) begin
      if (pop_q[0] == cyc) begin
        forced = 1'b1;
        void'(pop_q.pop_front());
      end
    end
    rd_en = forced || (rd_mode && ($urandom_range(0, 3) != 0));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (frame_done) fd_cnt++;
      if (rd_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, no word expected", rd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rd_data", rd_data, mon_exp);
        end
      end
    end
  end

  // Drives one frame and models its output words. abort_px>0 stops after that
  // many pixels of row 0 (de_in left high); force_first schedules pops that
  // coincide with the pushes of words force_first and force_first+1.
  task automatic drive_frame(input int hk, input int hp, input int vk, input int vp,
                             input int rs, input int abort_px, input int force_first);
    int kh, ph, kv, pv, g, gw;
    bit kept;
    logic [15:0] px [VW];
    int slot_of [VW];
    logic [15:0] line[$];
    logic [W-1:0] word;
    kh = hk; ph = hp; kv = vk; pv = vp;
    if (ph == 0 || kh == 0 || kh > ph) begin kh = 1; ph = 1; end
    if (pv == 0 || kv == 0 || kv > pv) begin kv = 1; pv = 1; end
    tick();
    de_in = 1'b0;
    vs_in = 1'b1;
    h_keep = 4'(hk); h_period = 4'(hp); v_keep = 4'(vk); v_period = 4'(vp);
    row_start = 11'(rs);
    exp_q.delete();
    model_words = 0;
    tick();
    tick();
    vs_in = 1'b0;
    g = 0;
    for (int r = 0; r < VH; r++) begin
      repeat (GAP) tick();
      kept = (r >= rs) && (((r - rs) % pv) < kv);
      line.delete();
      for (int x = 0; x < VW; x++) begin
        px[x] = 16'($urandom);
        slot_of[x] = -1;
        if (kept && ((x % ph) < kh) && (line.size() < OLP)) begin
          slot_of[x] = line.size();
          line.push_back(px[x]);
        end
      end
      if (abort_px > 0) begin
        for (int x = 0; x < abort_px; x++) begin
          tick();
          de_in = 1'b1;
          rgb565_in = px[x];
        end
        return;
      end
      if (kept) begin
        while (line.size() < OLP) line.push_back(16'd0);
        for (int w = 0; w < WPL; w++) begin
          word = '0;
          for (int k = 0; k < PPW; k++) word[16*k +: 16] = line[w*PPW + k];
          exp_q.push_back(word);
          model_words++;
        end
      end
      for (int x = 0; x < VW; x++) begin
        tick();
        de_in = 1'b1;
        rgb565_in = px[x];
        if (slot_of[x] >= 0 && (slot_of[x] % PPW) == PPW - 1) begin
          gw = g + slot_of[x] / PPW;
          if (force_first >= 0 && (gw == force_first || gw == force_first + 1))
            pop_q.push_back(cyc + 2);
        end
      end
      tick();
      de_in = 1'b0;
      if (kept) g += WPL;
    end
    repeat (GAP) tick();
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    rd_mode = 1'b1;
    while ((exp_q.size() != 0 || fifo_level != 0) && t < 4000) begin
      tick();
      t++;
    end
    repeat (6) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words still expected after %0d cycles", tag, exp_q.size(), t);
    end
  endtask

  task automatic run_frame(input string tag, input int hk, input int hp, input int vk,
                           input int vp, input int rs);
    int fd0, rx0;
    fd0 = fd_cnt;
    rx0 = rx_cnt;
    rd_mode = 1'b1;
    drive_frame(hk, hp, vk, vp, rs, 0, -1);
    drain(tag);
    check({tag, "_frame_done"}, W'(fd_cnt - fd0), W'(1));
    check({tag, "_words"}, W'(rx_cnt - rx0), W'(model_words));
    check({tag, "_overflow"}, W'(overflow), W'(0));
    check({tag, "_burst_ready"}, W'(burst_ready), W'(0));
  endtask

  initial begin
    int fd0, rx0;
    n_cmp = 0; n_fail = 0; fd_cnt = 0; rx_cnt = 0; cyc = 0; model_words = 0;
    rd_mode = 1'b0;
    rst = 1'b0; vs_in = 1'b0; de_in = 1'b0; rd_en = 1'b0; rgb565_in = 16'd0;
    h_keep = 4'd0; h_period = 4'd0; v_keep = 4'd0; v_period = 4'd0; row_start = 11'd0;
    repeat (3) tick();
    check("rst_fifo_level", W'(fifo_level), W'(0));
    check("rst_rd_valid", W'(rd_valid), W'(0));
    check("rst_rd_data", rd_data, W'(0));
    check("rst_burst_ready", W'(burst_ready), W'(0));
    check("rst_trans_id", W'(trans_id), W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    check("rst_frame_done", W'(frame_done), W'(0));
    check("rst_state_idle", W'(dbg_state), W'(0));
    rst = 1'b1;
    repeat (2) tick();
    check("idle_fifo_level", W'(fifo_level), W'(0));

    run_frame("h34_v34_rs3", 3, 4, 3, 4, 3);
    run_frame("h24_pad", 2, 4, 1, 1, 0);
    run_frame("invalid_cfg", 5, 4, 3, 0, 0);
    for (int i = 0; i < 4; i++)
      run_frame("random_cfg", $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 11));

    // FIFO saturation with the reader stalled
    rd_mode = 1'b0;
    check("hold_burst_before", W'(burst_ready), W'(0));
    drive_frame(1, 1, 1, 1, 0, 0, -1);
    check("hold_level_full", W'(fifo_level), W'(DEPTH));
    check("hold_overflow", W'(overflow), W'(1));
    check("hold_burst_ready", W'(burst_ready), W'(1));
    check("hold_trans_id", W'(trans_id), W'(1));

    // New frame clears the saturated FIFO; it is then cut off after 7 pixels.
    drive_frame(1, 1, 1, 1, 0, 7, -1);
    check("restart_level", W'(fifo_level), W'(1));
    check("restart_overflow", W'(overflow), W'(0));
    check("restart_burst_ready", W'(burst_ready), W'(0));
    rd_mode = 1'b1;
    run_frame("after_abort", 1, 1, 1, 1, 0);

    // Pops coinciding with pushes into a full FIFO
    fd0 = fd_cnt;
    rx0 = rx_cnt;
    rd_mode = 1'b0;
    drive_frame(1, 1, 1, 1, 4, 0, DEPTH);
    check("full_level", W'(fifo_level), W'(exp_q.size()));
    check("full_overflow", W'(overflow), W'(0));
    check("full_popped", W'(rx_cnt - rx0), W'(2));
    drain("full");
    check("full_words", W'(rx_cnt - rx0), W'(model_words));
    check("full_frame_done", W'(fd_cnt - fd0), W'(1));

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
